// File: rtl/sdram_tester_pkg.sv
// rtl/sdram_tester_pkg.sv - shared command/response types and sequencer state encoding
package sdram_tester_pkg;

    localparam int CMD_W = 31;
    localparam int RSP_W = 16;

    // Matches the serial-command FIFO word layout, MSB first.
    typedef struct packed {
        logic [20:0] addr;
        logic [7:0]  din;
        logic        aux;
        logic        write;
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACCESS,
        S_WAIT,
        S_PUSH
    } seq_state_t;

endpackage

// File: rtl/sdram_cmd_sequencer_stall_watchdog.sv
// rtl/sdram_cmd_sequencer_stall_watchdog.sv - saturating stall counter with threshold trip
module stall_watchdog #(
    parameter int THRESHOLD = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic tripped
);

    logic [15:0] count;
    logic [15:0] count_inc;

    always_comb begin
        count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (stall) begin
            count <= count_inc;
        end
    end

    // Trips on the same edge the count reaches the threshold.
    assign tripped = stall && (32'(count_inc) >= 32'(THRESHOLD));

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// rtl/sdram_cmd_sequencer.sv - command FIFO to SDRAM controller sequencer; optional SDRAM_SEQ_STATS_EN counters
module sdram_cmd_sequencer
    import sdram_tester_pkg::*;
#(
    parameter int RD_LATENCY    = 1,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic             clk8M,
    input  logic             rst,
    input  logic             sdram_ready,
    input  logic             cmd_empty,
    input  logic [CMD_W-1:0] cmd_q,
    output logic             cmd_rd_en,
    output logic [20:0]      sdram_addr,
    output logic [7:0]       sdram_din,
    output logic             sdram_aux,
    output logic             sdram_we,
    input  logic [RSP_W-1:0] sdram_dout,
    input  logic             rsp_full,
    output logic             rsp_wr_en,
    output logic [RSP_W-1:0] rsp_data,
    output logic             busy,
    output logic             seq_error
`ifdef SDRAM_SEQ_STATS_EN
    ,
    output logic [15:0]      wr_count,
    output logic [15:0]      rd_count
`endif
);

    seq_state_t state;
    seq_state_t state_next;
    sdram_cmd_t cmd;
    logic [2:0] lat_cnt;
    logic       stall;
    logic       tripped;

    assign cmd  = sdram_cmd_t'(cmd_q);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk8M) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are gated by rst so nothing is popped or pushed in the reset cycle.
    always_comb begin
        state_next = state;
        cmd_rd_en  = 1'b0;
        rsp_wr_en  = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cmd_empty && sdram_ready && !rst) begin
                    cmd_rd_en  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH:  state_next = S_ACCESS;
            S_ACCESS: state_next = sdram_we ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (lat_cnt == 3'd0) begin
                    state_next = S_PUSH;
                end
            end
            S_PUSH: begin
                if (!rsp_full) begin
                    rsp_wr_en  = !rst;
                    state_next = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk8M) begin
        if (rst) begin
            sdram_addr <= '0;
            sdram_din  <= '0;
            sdram_aux  <= 1'b0;
            sdram_we   <= 1'b0;
            lat_cnt    <= '0;
            rsp_data   <= '0;
            seq_error  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    sdram_addr <= cmd.addr;
                    sdram_din  <= cmd.din;
                    sdram_aux  <= cmd.aux;
                    sdram_we   <= cmd.write;
                end
                S_ACCESS: begin
                    sdram_we <= 1'b0;
                    lat_cnt  <= 3'(RD_LATENCY - 1);
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        rsp_data <= sdram_dout;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
            if (tripped) begin
                seq_error <= 1'b1;
            end
        end
    end

    stall_watchdog #(
        .THRESHOLD (STALL_TIMEOUT)
    ) u_stall_watchdog (
        .clk     (clk8M),
        .rst     (rst),
        .clear   (rsp_wr_en),
        .stall   (stall),
        .tripped (tripped)
    );

`ifdef SDRAM_SEQ_STATS_EN
    always_ff @(posedge clk8M) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (state == S_ACCESS && sdram_we) begin
                wr_count <= wr_count + 16'd1;
            end
            if (rsp_wr_en) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb/tb_sdram_cmd_sequencer.sv - randomized and directed bench against a cycle-schedule model
module tb_sdram_cmd_sequencer;
    import sdram_tester_pkg::*;

    localparam int RL    = 1;
    localparam int ST    = 1024;
    localparam int NEVER = 32'h7fff_ffff;

    logic             clk8M = 1'b0;
    logic             rst;
    logic             sdram_ready;
    logic             cmd_empty;
    logic [CMD_W-1:0] cmd_q;
    logic             cmd_rd_en;
    logic [20:0]      sdram_addr;
    logic [7:0]       sdram_din;
    logic             sdram_aux;
    logic             sdram_we;
    logic [RSP_W-1:0] sdram_dout;
    logic             rsp_full;
    logic             rsp_wr_en;
    logic [RSP_W-1:0] rsp_data;
    logic             busy;
    logic             seq_error;
`ifdef SDRAM_SEQ_STATS_EN
    logic [15:0]      wr_count;
    logic [15:0]      rd_count;
`endif

    always #5 clk8M = ~clk8M;

    sdram_cmd_sequencer #(
        .RD_LATENCY    (RL),
        .STALL_TIMEOUT (ST)
    ) dut (
        .clk8M       (clk8M),
        .rst         (rst),
        .sdram_ready (sdram_ready),
        .cmd_empty   (cmd_empty),
        .cmd_q       (cmd_q),
        .cmd_rd_en   (cmd_rd_en),
        .sdram_addr  (sdram_addr),
        .sdram_din   (sdram_din),
        .sdram_aux   (sdram_aux),
        .sdram_we    (sdram_we),
        .sdram_dout  (sdram_dout),
        .rsp_full    (rsp_full),
        .rsp_wr_en   (rsp_wr_en),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .seq_error   (seq_error)
`ifdef SDRAM_SEQ_STATS_EN
        ,
        .wr_count    (wr_count),
        .rd_count    (rd_count)
`endif
    );

    int         n_pass;
    int         n_total;
    sdram_cmd_t fifo[$];
    bit         force_empty;
    bit         rnd_mode;

    // Schedule model: each popped command fixes the cycles its effects must appear on.
    int          cyc;
    int          free_at;
    int          pop_cyc;
    int          stall_run;
    bit          active;
    bit          model_on;
    bit          m_pop;
    bit          e_rd_en;
    bit          e_wr_en;
    bit          e_we;
    bit          e_busy;
    bit          exp_err;
    sdram_cmd_t  cur;
    sdram_cmd_t  shown;
    logic [15:0] exp_data;
    logic [15:0] m_wr;
    logic [15:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic sdram_cmd_t mk(input logic [20:0] a, input logic [7:0] d, input logic x, input logic w);
        sdram_cmd_t c;
        c.addr  = a;
        c.din   = d;
        c.aux   = x;
        c.write = w;
        return c;
    endfunction

    task automatic upd_empty();
        cmd_empty = force_empty || (fifo.size() == 0);
    endtask

    task automatic model_check();
        e_busy  = cyc < free_at;
        e_rd_en = !rst && !e_busy && !cmd_empty && sdram_ready;
        e_we    = active && cur.write && (cyc == pop_cyc + 2);
        e_wr_en = !rst && active && !cur.write && (cyc >= pop_cyc + 3 + RL) && !rsp_full;
        if (!model_on) return;
        check("cmd_rd_en", cmd_rd_en, e_rd_en);
        check("rsp_wr_en", rsp_wr_en, e_wr_en);
        if (rst) return;
        check("busy", busy, e_busy);
        check("sdram_we", sdram_we, e_we);
        check("sdram_addr", sdram_addr, shown.addr);
        check("sdram_din", sdram_din, shown.din);
        check("sdram_aux", sdram_aux, shown.aux);
        check("rsp_data", rsp_data, exp_data);
        check("seq_error", seq_error, exp_err);
`ifdef SDRAM_SEQ_STATS_EN
        check("wr_count", wr_count, m_wr);
        check("rd_count", rd_count, m_rd);
`endif
    endtask

    task automatic model_advance();
        m_pop = 1'b0;
        if (rst) begin
            model_on  = 1'b1;
            active    = 1'b0;
            free_at   = cyc + 1;
            shown     = '0;
            exp_data  = '0;
            exp_err   = 1'b0;
            stall_run = 0;
            m_wr      = '0;
            m_rd      = '0;
        end else begin
            if (e_rd_en) begin
                m_pop   = 1'b1;
                active  = 1'b1;
                cur     = fifo[0];
                pop_cyc = cyc;
                free_at = cur.write ? cyc + 3 : NEVER;
            end
            if (active && cyc == pop_cyc + 1) shown = cur;
            if (active && cur.write && cyc == pop_cyc + 2) begin
                m_wr   = m_wr + 16'd1;
                active = 1'b0;
            end
            if (active && !cur.write && cyc == pop_cyc + 2 + RL) exp_data = sdram_dout;
            if (active && !cur.write && cyc >= pop_cyc + 3 + RL) begin
                if (!rsp_full) begin
                    m_rd      = m_rd + 16'd1;
                    stall_run = 0;
                    active    = 1'b0;
                    free_at   = cyc + 1;
                end else begin
                    if (stall_run < 65535) stall_run++;
                    if (stall_run >= ST) exp_err = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic drive();
        if (m_pop) cmd_q = fifo.pop_front();
        else cmd_q = CMD_W'($urandom);
        sdram_dout = 16'($urandom);
        if (rnd_mode) begin
            if (fifo.size() < 4) fifo.push_back(sdram_cmd_t'(CMD_W'($urandom)));
            sdram_ready = ($urandom_range(0, 9) != 0);
            force_empty = ($urandom_range(0, 3) == 0);
            rsp_full    = ($urandom_range(0, 2) == 0);
            rst         = ($urandom_range(0, 499) == 0);
        end
        upd_empty();
    endtask

    task automatic tick();
        @(negedge clk8M);
        model_check();
        @(posedge clk8M);
        model_advance();
        #1;
        drive();
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int pops;
        int wes;
        int wrs;
        int last;
        int gap_bad;

        n_pass = 0; n_total = 0; cyc = 0; free_at = 0; model_on = 0; active = 0;
        rnd_mode = 0; force_empty = 1; rst = 1; sdram_ready = 0; rsp_full = 0;
        cmd_q = '0; sdram_dout = '0; shown = '0; cur = '0; exp_data = '0;
        m_wr = '0; m_rd = '0; exp_err = 0; stall_run = 0; pop_cyc = 0;
        upd_empty();
        tick();
        tick();
        rst = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_we", sdram_we, 0);
        check("rst_addr", sdram_addr, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_seq_error", seq_error, 0);

        // Single write
        sdram_ready = 1; force_empty = 0;
        fifo.push_back(mk(21'h012345, 8'hA5, 1'b1, 1'b1));
        upd_empty(); #1;
        check("w_pop", cmd_rd_en, 1);
        tick();
        check("w_fetch_we", sdram_we, 0);
        tick();
        check("w_addr", sdram_addr, 21'h012345);
        check("w_din", sdram_din, 8'hA5);
        check("w_aux", sdram_aux, 1);
        check("w_we", sdram_we, 1);
        tick();
        check("w_we_off", sdram_we, 0);
        check("w_addr_hold", sdram_addr, 21'h012345);
        check("w_idle", busy, 0);

        // Single read, latency 1
        fifo.push_back(mk(21'($urandom), 8'($urandom), 1'b0, 1'b0));
        upd_empty(); #1;
        check("r_pop", cmd_rd_en, 1);
        tick(); tick(); tick();
        sdram_dout = 16'hBEEF; #1;
        tick();
        check("r_wr_en", rsp_wr_en, 1);
        check("r_data", rsp_data, 16'hBEEF);
        tick();
        check("r_wr_en_off", rsp_wr_en, 0);
        check("r_idle", busy, 0);

        // Ten back-to-back writes
        for (int i = 0; i < 10; i++) fifo.push_back(mk(21'($urandom), 8'($urandom), 1'($urandom), 1'b1));
        upd_empty(); #1;
        pops = 0; wes = 0; wrs = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_rd_en) begin
                if (last >= 0 && cyc - last != 3) gap_bad++;
                last = cyc;
                pops++;
            end
            wes += int'(sdram_we);
            wrs += int'(rsp_wr_en);
            tick();
        end
        check("b2b_pops", pops, 10);
        check("b2b_we_pulses", wes, 10);
        check("b2b_rsp_wr_en", wrs, 0);
        check("b2b_gap_bad", gap_bad, 0);

        // Not ready holds off the pop
        sdram_ready = 0;
        fifo.push_back(mk(21'($urandom), 8'($urandom), 1'b0, 1'b1));
        upd_empty(); #1;
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            pops += int'(cmd_rd_en);
            tick();
        end
        check("nr_pops", pops, 0);
        sdram_ready = 1; #1;
        check("nr_pop_on_ready", cmd_rd_en, 1);
        for (int i = 0; i < 4; i++) tick();

        // Response stall beyond the timeout
        rsp_full = 1;
        fifo.push_back(mk(21'($urandom), 8'($urandom), 1'b1, 1'b0));
        upd_empty(); #1;
        check("st_pop", cmd_rd_en, 1);
        tick(); tick(); tick();
        sdram_dout = 16'h5A3C; #1;
        tick();
        for (int k = 0; k < ST - 1; k++) tick();
        check("st_err_before", seq_error, 0);
        tick();
        check("st_err_after", seq_error, 1);
        for (int k = 0; k < 76; k++) tick();
        check("st_no_push_while_full", rsp_wr_en, 0);
        rsp_full = 0; #1;
        check("st_release_wr_en", rsp_wr_en, 1);
        check("st_release_data", rsp_data, 16'h5A3C);
        tick();
        check("st_single_push", rsp_wr_en, 0);
        check("st_err_sticky", seq_error, 1);

        // Reset while waiting for read data
        fifo.push_back(mk(21'($urandom), 8'($urandom), 1'b1, 1'b0));
        upd_empty(); #1;
        check("rw_pop", cmd_rd_en, 1);
        tick(); tick(); tick();
        check("rw_busy_wait", busy, 1);
        rst = 1; force_empty = 1; upd_empty(); #1;
        tick();
        rst = 0; #1;
        check("rw_rd_en", cmd_rd_en, 0);
        check("rw_wr_en", rsp_wr_en, 0);
        check("rw_busy", busy, 0);
        check("rw_we", sdram_we, 0);
        check("rw_addr", sdram_addr, 0);
        check("rw_din", sdram_din, 0);
        check("rw_aux", sdram_aux, 0);
        check("rw_data", rsp_data, 0);
        check("rw_err", seq_error, 0);
`ifdef SDRAM_SEQ_STATS_EN
        check("rw_wr_count", wr_count, 0);
        check("rw_rd_count", rd_count, 0);
`endif

        // Randomized traffic against the model
        rnd_mode = 1;
        for (int i = 0; i < 4000; i++) tick();
        rnd_mode = 0; rst = 0; rsp_full = 0; force_empty = 1; sdram_ready = 1;
        upd_empty();
        for (int i = 0; i < 12; i++) tick();
        check("end_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
